feature_loader: RTL and testbench

Fetches one input feature map from external memory in bursts and feeds the two 8-channel feature buffer FIFOs that sit directly downstream. Each memory beat carries 4 pixels × 8 channels. For 16-channel maps, bursts alternate between patch 1 (channels 0-7) and patch 2 (channels 8-15) so both FIFOs fill in step. Started by the same `load_feature_begin` pulse that resets the downstream FIFOs.

---
 rtl/feature_loader_pkg.sv | 16 +
 rtl/feature_loader.sv | 158 +++++++++++++++
 tb/tb_feature_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/feature_loader_pkg.sv
// rtl/feature_loader_pkg.sv - shared parameters and FSM encodings for the feature loader
package feature_loader_pkg;

    localparam int FEATURE_WIDTH      = 8;
    localparam int DEF_MEM_DATA_WIDTH = 32 * FEATURE_WIDTH;
    localparam int DEF_BURST_LEN      = 16;
    localparam int DEF_RST_WAIT       = 8;
    localparam int REMAIN_WIDTH       = 18;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_RST = 3'd1;
    localparam logic [2:0] ST_REQ      = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

endpackage

// File: rtl/feature_loader.sv
// rtl/feature_loader.sv - bursts one feature map from memory into the two feature buffer FIFOs
module feature_loader
    import feature_loader_pkg::*;
#(
    parameter int MEM_DATA_WIDTH = DEF_MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH     = 32,
    parameter int BURST_LEN      = DEF_BURST_LEN,
    parameter int RST_WAIT       = DEF_RST_WAIT
) (
    input  logic                      system_clk,
    input  logic                      rst_n,
    input  logic                      load_feature_begin,
    input  logic [ADDR_WIDTH-1:0]     feature_base_addr,
    input  logic [ADDR_WIDTH-1:0]     patch2_offset,
    input  logic [9:0]                row_size,
    input  logic [9:0]                col_size,
    input  logic                      feature_double_patch,
    output logic                      busy,
    output logic                      load_feature_finish,
    output logic                      mem_rd_req,
    output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
    output logic [7:0]                mem_rd_len,
    input  logic                      mem_rd_ack,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
    input  logic                      mem_rd_valid,
    input  logic                      mem_rd_last,
    output logic [MEM_DATA_WIDTH-1:0] feature_data,
    output logic                      feature_buffer_1_valid,
    output logic                      feature_buffer_2_valid,
    input  logic                      feature_buffer_1_ready,
    input  logic                      feature_buffer_2_ready
);

    localparam int BPB    = MEM_DATA_WIDTH / 8;
    localparam int WAIT_W = (RST_WAIT > 1) ? $clog2(RST_WAIT) : 1;

    logic [2:0]              state;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [ADDR_WIDTH-1:0]   addr1;
    logic [ADDR_WIDTH-1:0]   addr2;
    logic [REMAIN_WIDTH-1:0] remaining;
    logic [REMAIN_WIDTH-1:0] burst_len;
    logic                    patch;
    logic                    double_patch;
    // set when a restart arrives mid-burst: the outstanding beats must be consumed but not forwarded
    logic                    drain;

    logic [19:0]             area;
    logic [REMAIN_WIDTH-1:0] total_new;
    logic [REMAIN_WIDTH-1:0] cur_len;
    logic [REMAIN_WIDTH-1:0] rem_after;
    logic [ADDR_WIDTH-1:0]   addr_step;
    logic                    sel_ready;
    logic                    beat_last;

    // derived burst sizing, request outputs and beat-count arithmetic
    always_comb begin
        area      = row_size * col_size;
        total_new = REMAIN_WIDTH'((21'(area) + 21'd3) >> 2);
        cur_len   = (remaining > REMAIN_WIDTH'(BURST_LEN)) ? REMAIN_WIDTH'(BURST_LEN) : remaining;
        rem_after = (double_patch && !patch) ? remaining : remaining - burst_len;
        addr_step = ADDR_WIDTH'(burst_len) * ADDR_WIDTH'(BPB);
        sel_ready = patch ? feature_buffer_2_ready : feature_buffer_1_ready;
        beat_last = (state == ST_DATA) && mem_rd_valid && mem_rd_last;
        busy        = (state != ST_IDLE);
        mem_rd_req  = (state == ST_REQ) && sel_ready;
        mem_rd_addr = patch ? addr2 : addr1;
        mem_rd_len  = 8'(cur_len - REMAIN_WIDTH'(1));
    end

    // control FSM, address/remaining bookkeeping and the registered FIFO write path
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= ST_IDLE;
            wait_cnt               <= '0;
            addr1                  <= '0;
            addr2                  <= '0;
            remaining              <= '0;
            burst_len              <= '0;
            patch                  <= 1'b0;
            double_patch           <= 1'b0;
            drain                  <= 1'b0;
            feature_data           <= '0;
            feature_buffer_1_valid <= 1'b0;
            feature_buffer_2_valid <= 1'b0;
            load_feature_finish    <= 1'b0;
        end else begin
            feature_buffer_1_valid <= 1'b0;
            feature_buffer_2_valid <= 1'b0;
            load_feature_finish    <= 1'b0;

            if ((state == ST_DATA) && mem_rd_valid && !drain) begin
                feature_data           <= mem_rd_data;
                feature_buffer_1_valid <= !patch;
                feature_buffer_2_valid <= patch;
            end

            if (load_feature_begin) begin
                addr1        <= feature_base_addr;
                addr2        <= feature_base_addr + patch2_offset;
                remaining    <= total_new;
                patch        <= 1'b0;
                double_patch <= feature_double_patch;
                wait_cnt     <= '0;
                if ((state == ST_DATA) && !beat_last) begin
                    drain <= 1'b1;
                end else if (mem_rd_req && mem_rd_ack) begin
                    // memory already owes a burst for this request, so swallow it first
                    drain <= 1'b1;
                    state <= ST_DATA;
                end else begin
                    drain <= 1'b0;
                    state <= ST_WAIT_RST;
                end
            end else begin
                case (state)
                    ST_WAIT_RST: begin
                        if (wait_cnt == WAIT_W'(RST_WAIT - 1)) begin
                            state <= (remaining != '0) ? ST_REQ : ST_DONE;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                    ST_REQ: begin
                        if (mem_rd_req && mem_rd_ack) begin
                            burst_len <= cur_len;
                            state     <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (beat_last) begin
                            if (drain) begin
                                drain    <= 1'b0;
                                wait_cnt <= '0;
                                state    <= ST_WAIT_RST;
                            end else begin
                                if (patch) begin
                                    addr2 <= addr2 + addr_step;
                                end else begin
                                    addr1 <= addr1 + addr_step;
                                end
                                patch     <= double_patch && !patch;
                                remaining <= rem_after;
                                state     <= (rem_after != '0) ? ST_REQ : ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        load_feature_finish <= 1'b1;
                        state               <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_feature_loader.sv
// tb/tb_feature_loader.sv - scoreboard bench for feature_loader
module tb_feature_loader;
    import feature_loader_pkg::*;

    localparam int DW  = DEF_MEM_DATA_WIDTH;
    localparam int AW  = 32;
    localparam int BPB = DW / 8;
    localparam int RW  = DEF_RST_WAIT;

    logic          system_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_feature_begin = 1'b0;
    logic [AW-1:0] feature_base_addr = '0;
    logic [AW-1:0] patch2_offset = '0;
    logic [9:0]    row_size = '0;
    logic [9:0]    col_size = '0;
    logic          feature_double_patch = 1'b0;
    logic          busy;
    logic          load_feature_finish;
    logic          mem_rd_req;
    logic [AW-1:0] mem_rd_addr;
    logic [7:0]    mem_rd_len;
    logic          mem_rd_ack;
    logic [DW-1:0] mem_rd_data;
    logic          mem_rd_valid;
    logic          mem_rd_last;
    logic [DW-1:0] feature_data;
    logic          feature_buffer_1_valid;
    logic          feature_buffer_2_valid;
    logic          feature_buffer_1_ready = 1'b1;
    logic          feature_buffer_2_ready = 1'b1;

    feature_loader dut (
        .system_clk(system_clk), .rst_n(rst_n), .load_feature_begin(load_feature_begin),
        .feature_base_addr(feature_base_addr), .patch2_offset(patch2_offset),
        .row_size(row_size), .col_size(col_size), .feature_double_patch(feature_double_patch),
        .busy(busy), .load_feature_finish(load_feature_finish),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len),
        .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
        .mem_rd_last(mem_rd_last), .feature_data(feature_data),
        .feature_buffer_1_valid(feature_buffer_1_valid), .feature_buffer_2_valid(feature_buffer_2_valid),
        .feature_buffer_1_ready(feature_buffer_1_ready), .feature_buffer_2_ready(feature_buffer_2_ready)
    );

    always #5 system_clk = ~system_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int fin_cnt = 0;
    int last_strobe_cyc = -100;
    int first_req_cyc = -1;
    int bcyc = 0;
    int beat_idx = 0;

    logic [DW-1:0] exp_data_q[$];
    logic          exp_buf_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [7:0]    exp_len_q[$];

    always @(posedge system_clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {(DW/AW){a}};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beats(input logic [AW-1:0] base, input int n, input logic buf_id);
        for (int i = 0; i < n; i++) begin
            exp_data_q.push_back(pat(base + AW'(i * BPB)));
            exp_buf_q.push_back(buf_id);
        end
    endtask

    task automatic push_req(input logic [AW-1:0] a, input logic [7:0] l);
        exp_addr_q.push_back(a);
        exp_len_q.push_back(l);
    endtask

    // scoreboard monitor: every strobe and every accepted request is popped and compared
    always @(negedge system_clk) begin
        if (rst_n) begin
            if (feature_buffer_1_valid || feature_buffer_2_valid) begin
                strobe_cnt++;
                last_strobe_cyc = cyc;
                check("valid_exclusive", DW'(feature_buffer_1_valid & feature_buffer_2_valid), '0);
                if (exp_data_q.size() == 0) begin
                    check("unexpected_strobe", DW'(1), DW'(0));
                end else begin
                    check("strobe_buffer", DW'(feature_buffer_2_valid), DW'(exp_buf_q.pop_front()));
                    check("strobe_data", feature_data, exp_data_q.pop_front());
                end
            end
            if (mem_rd_req && first_req_cyc < 0) first_req_cyc = cyc;
            if (mem_rd_req && mem_rd_ack) begin
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_req", DW'(mem_rd_addr), DW'(0));
                end else begin
                    check("req_addr", DW'(mem_rd_addr), DW'(exp_addr_q.pop_front()));
                    check("req_len", DW'(mem_rd_len), DW'(exp_len_q.pop_front()));
                end
            end
            if (load_feature_finish) fin_cnt++;
        end
    end

    // memory model: acks any request, returns len+1 beats whose data encode the beat address
    initial begin
        logic [AW-1:0] a;
        logic [7:0]    l;
        mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_last = 1'b0; mem_rd_data = '0;
        forever begin
            @(posedge system_clk); #2;
            if (rst_n && mem_rd_req) begin
                a = mem_rd_addr;
                l = mem_rd_len;
                mem_rd_ack = 1'b1;
                @(posedge system_clk); #2;
                mem_rd_ack = 1'b0;
                for (int i = 0; i <= int'(l); i++) begin
                    beat_idx     = i;
                    mem_rd_valid = 1'b1;
                    mem_rd_last  = (i == int'(l));
                    mem_rd_data  = pat(a + AW'(i * BPB));
                    @(posedge system_clk); #2;
                end
                mem_rd_valid = 1'b0;
                mem_rd_last  = 1'b0;
            end
        end
    end

    task automatic start(input logic [AW-1:0] base, input logic [AW-1:0] off,
                         input logic [9:0] r, input logic [9:0] c, input logic dbl);
        @(posedge system_clk); #1;
        feature_base_addr = base; patch2_offset = off;
        row_size = r; col_size = c; feature_double_patch = dbl;
        load_feature_begin = 1'b1;
        bcyc = cyc;
        first_req_cyc = -1;
        @(negedge system_clk);
        check("busy_before_start", DW'(busy), '0);
        @(posedge system_clk); #1;
        load_feature_begin = 1'b0;
        @(negedge system_clk);
        check("busy_after_start", DW'(busy), DW'(1));
    endtask

    task automatic wait_finish(input logic expect_strobes);
        int k = 0;
        while (!load_feature_finish && k < 5000) begin
            @(negedge system_clk);
            k++;
        end
        check("finish_seen", DW'(load_feature_finish), DW'(1));
        check("busy_low_at_finish", DW'(busy), '0);
        if (expect_strobes) check("finish_latency", DW'(cyc - last_strobe_cyc), DW'(1));
        @(negedge system_clk);
        check("strobes_outstanding", DW'(exp_data_q.size()), '0);
        check("reqs_outstanding", DW'(exp_addr_q.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s0;
        int f0;
        int k;
        repeat (3) @(posedge system_clk);
        @(negedge system_clk);
        check("rst_busy", DW'(busy), '0);
        check("rst_finish", DW'(load_feature_finish), '0);
        check("rst_req", DW'(mem_rd_req), '0);
        check("rst_valids", DW'({feature_buffer_1_valid, feature_buffer_2_valid}), '0);
        check("rst_data", feature_data, '0);
        @(posedge system_clk); #1;
        rst_n = 1'b1;

        // 4x4 single patch: one request of 4 beats
        push_req(32'h1000, 8'd3);
        push_beats(32'h1000, 4, 1'b0);
        start(32'h1000, 32'h0, 10'd4, 10'd4, 1'b0);
        wait_finish(1'b1);
        check("first_req_latency", DW'(first_req_cyc - bcyc), DW'(RW + 1));

        // 20x20 single patch: six full bursts then one of 4 beats
        for (int b = 0; b < 6; b++) push_req(32'h20000 + AW'(b * 16 * BPB), 8'd15);
        push_req(32'h20000 + AW'(96 * BPB), 8'd3);
        push_beats(32'h20000, 100, 1'b0);
        s0 = strobe_cnt;
        start(32'h20000, 32'h0, 10'd20, 10'd20, 1'b0);
        wait_finish(1'b1);
        check("strobes_20x20", DW'(strobe_cnt - s0), DW'(100));

        // 8x8 double patch: alternating patch bursts
        push_req(32'h10000, 8'd15);
        push_req(32'h18000, 8'd15);
        push_beats(32'h10000, 16, 1'b0);
        push_beats(32'h18000, 16, 1'b1);
        start(32'h10000, 32'h8000, 10'd8, 10'd8, 1'b1);
        wait_finish(1'b1);

        // ready held low while in REQ
        feature_buffer_1_ready = 1'b0;
        push_req(32'h4000, 8'd3);
        push_beats(32'h4000, 4, 1'b0);
        start(32'h4000, 32'h0, 10'd4, 10'd4, 1'b0);
        repeat (RW + 1) @(negedge system_clk);
        s0 = strobe_cnt;
        for (int i = 0; i < 50; i++) begin
            check("stall_req", DW'(mem_rd_req), '0);
            check("stall_addr", DW'(mem_rd_addr), DW'(32'h4000));
            check("stall_len", DW'(mem_rd_len), DW'(3));
            check("stall_strobes", DW'(strobe_cnt - s0), '0);
            @(negedge system_clk);
        end
        @(posedge system_clk); #1;
        feature_buffer_1_ready = 1'b1;
        wait_finish(1'b1);

        // restart on beat 5 of a 16-beat burst
        f0 = fin_cnt;
        push_req(32'h2000, 8'd15);
        push_beats(32'h2000, 5, 1'b0);
        push_req(32'h3000, 8'd3);
        push_beats(32'h3000, 4, 1'b0);
        start(32'h2000, 32'h0, 10'd8, 10'd8, 1'b0);
        k = 0;
        while (!(mem_rd_valid && beat_idx == 4) && k < 200) begin
            @(negedge system_clk);
            k++;
        end
        check("abort_beat5_reached", DW'(mem_rd_valid && beat_idx == 4), DW'(1));
        feature_base_addr = 32'h3000; row_size = 10'd4; col_size = 10'd4;
        load_feature_begin = 1'b1;
        @(posedge system_clk); #1;
        load_feature_begin = 1'b0;
        wait_finish(1'b1);
        check("abort_finish_count", DW'(fin_cnt - f0), DW'(1));

        // empty map: no request, finish RST_WAIT+2 cycles after begin
        start(32'h5000, 32'h0, 10'd0, 10'd5, 1'b0);
        k = 0;
        while (!load_feature_finish && k < 100) begin
            @(negedge system_clk);
            k++;
        end
        check("empty_finish_latency", DW'(cyc - bcyc), DW'(RW + 2));
        check("empty_no_req", DW'(first_req_cyc), DW'(-1));
        wait_finish(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
